data_mem_responder: RTL and testbench

- Responder side of the core's data-memory interface; the program counter and load/store path act as initiator.
- Accepts one load or store request at a time and holds `dmem_valid` low for a fixed number of wait cycles.
- Then commits the store, or returns sign/zero-extended load data, and raises `dmem_valid` again so the PC releases its stall.
- Backed by a word-organised internal RAM with byte-lane writes.

---
 rtl/data_mem_responder_pkg.sv | 67 ++++++
 rtl/data_mem_responder_ram.sv | 36 +++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
//   size_e      : access size encoding carried on req_size (3 is illegal)
//   state_e     : responder FSM states
//   lane_mask   : byte-enable for a store of a given size/offset
//   store_lanes : replicates right-justified store data onto every lane
//   load_extend : picks the addressed byte/half out of a word and extends it
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Replicating the data means the lane mask alone decides what lands
  // where, so no shifter is needed on the write path.
  function automatic logic [31:0] store_lanes(input logic [1:0] size,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  offset,
                                              input logic        is_unsigned);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] result;
    sel_byte = word[{offset, 3'b000} +: 8];
    sel_half = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: result = is_unsigned ? {24'h0, sel_byte}
                                    : {{24{sel_byte[7]}}, sel_byte};
      SZ_HALF: result = is_unsigned ? {16'h0, sel_half}
                                    : {{16{sel_half[15]}}, sel_half};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Word-organised RAM with byte-lane writes and a registered read port.
//   clk   : clock
//   we    : write enable, qualified per lane by be
//   be    : byte enables, bit i covers wdata[8i+7:8i]
//   waddr : word index for writes
//   wdata : lane-aligned write data
//   raddr : word index for reads, data appears on rdata after the next edge
//   rdata : registered read data
// Contents are deliberately not reset.
module data_mem_responder_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the core's data-memory interface. One load or store is
// accepted at a time; dmem_valid drops for LATENCY cycles while the request
// is in flight, then the access is committed and rsp_done pulses.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : request present (looked at only while idle)
//   req_we        : 1 = store, 0 = load
//   req_addr      : byte address
//   req_size      : 0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned  : zero-extend sub-word loads when set
//   req_wdata     : right-justified store data
//   dmem_valid    : high when idle/ready, low while a request is in flight
//   rsp_done      : one-cycle completion pulse
//   rdata         : load result, held until the next load (or fault) completes
//   err           : one-cycle fault pulse coincident with rsp_done
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        dmem_valid,
  output logic        rsp_done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        complete;
  logic        fault;
  logic        ram_we;
  logic [AW-1:0] ram_raddr;
  logic [31:0] ram_rdata;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign complete = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  assign fault = (size_q == SZ_ILLEGAL)
              || ((size_q == SZ_HALF) && addr_q[0])
              || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
              || (addr_q[31:2] >= 30'(DEPTH));

  // The read is issued every cycle: from the live request while idle (so a
  // LATENCY of 1 still has its data at completion) and from the captured
  // address while waiting, which covers the counter = 1 slot.
  assign ram_raddr = (state_q == ST_IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];

  // A reset landing on the completion edge must abort the store too.
  assign ram_we = complete && we_q && !fault && !rst;

  assign dmem_valid = (state_q == ST_IDLE);

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request capture and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      rsp_done   <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'h0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rsp_done <= complete;
      err      <= complete && fault;
      if (accept) begin
        we_q       <= req_we;
        addr_q     <= req_addr;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata;
      end
      if (complete) begin
        if (fault) begin
          rdata <= 32'h0;
        end else if (!we_q) begin
          rdata <= load_extend(ram_rdata, size_q, addr_q[1:0], unsigned_q);
        end
      end
    end
  end

  data_mem_responder_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (lane_mask(size_q, addr_q[1:0])),
    .waddr(addr_q[AW+1:2]),
    .wdata(store_lanes(size_q, wdata_q)),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a byte-array reference model predicts
// fault, load data and held rdata for directed and random traffic.
module tb_data_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        dmem_valid;
  logic        rsp_done;
  logic [31:0] rdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .dmem_valid  (dmem_valid),
    .rsp_done    (rsp_done),
    .rdata       (rdata),
    .err         (err)
  );

  // Reference model: memory as a flat little-endian byte array.
  function automatic void model_exec(input logic we, input logic [31:0] addr,
                                     input logic [1:0] size, input logic uns,
                                     input logic [31:0] wdata, output logic e_err);
    int n;
    logic [31:0] v;
    e_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH);
    if (e_err) begin
      ref_rdata = 32'h0;
      return;
    end
    n = 1 << size;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
      if (!uns && n < 4 && v[8*n-1]) begin
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      ref_rdata = v;
    end
  endfunction

  // Presents a request in the current idle cycle and returns at the falling
  // edge of the cycle where dmem_valid is back high. With hold set the
  // request lines stay asserted with garbage while the request is in flight.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input bit hold,
                       output int low, output logic o_done, output logic o_err,
                       output logic [31:0] o_rdata, output bit early_done);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    if (hold) begin
      req_we       = 1'($urandom);
      req_addr     = $urandom;
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_wdata    = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    low        = 0;
    early_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dmem_valid) break;
      low++;
      if (rsp_done) early_done = 1'b1;
    end
    o_done  = rsp_done;
    o_err   = err;
    o_rdata = rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (dmem_valid !== 1'b1 || rsp_done !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle c%0d: got valid=%b done=%b rdata=%h err=%b want 1 0 0 0",
                 c, dmem_valid, rsp_done, rdata, err);
      end
    end
    ref_rdata = 32'h0;
  endtask

  // Fills every word so later loads compare against known contents.
  task automatic test_fill();
    int low; logic d, e, ee; logic [31:0] r; bit early;
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      issue(1'b1, 32'(i*4), 2'd2, 1'b0, w, 1'b1, low, d, e, r, early);
      model_exec(1'b1, 32'(i*4), 2'd2, 1'b0, w, ee);
      total++;
      if (low !== LATENCY || d !== 1'b1 || e !== ee || early) begin
        bad++;
        $display("[TB] FAIL fill_%0d: got low=%0d done=%b err=%b early=%b want %0d 1 %b 0",
                 i, low, d, e, early, LATENCY, ee);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int low; logic d, e, ee; logic [31:0] r; bit early;
    logic        t_we   [7] = '{1, 0, 1, 0, 0, 0, 0};
    logic [31:0] t_addr [7] = '{32'h10, 32'h10, 32'h11, 32'h11, 32'h11, 32'h10, 32'h12};
    logic [1:0]  t_size [7] = '{2, 2, 0, 0, 0, 2, 1};
    logic        t_uns  [7] = '{0, 0, 0, 0, 1, 0, 0};
    logic [31:0] t_wd   [7] = '{32'hDEADBEEF, 0, 32'h80, 0, 0, 0, 0};
    logic [31:0] t_exp  [7] = '{32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFF80,
                                32'h00000080, 32'hDEAD80EF, 32'hFFFFDEAD};
    for (int i = 0; i < 7; i++) begin
      issue(t_we[i], t_addr[i], t_size[i], t_uns[i], t_wd[i], 1'b0, low, d, e, r, early);
      model_exec(t_we[i], t_addr[i], t_size[i], t_uns[i], t_wd[i], ee);
      total++;
      if (low !== LATENCY || d !== 1'b1 || e !== 1'b0 || early) begin
        bad++;
        $display("[TB] FAIL directed_timing_%0d: got low=%0d done=%b err=%b want %0d 1 0",
                 i, low, d, e, LATENCY);
      end
      if (i > 0) begin
        total++;
        if (r !== t_exp[i] || r !== ref_rdata) begin
          bad++;
          $display("[TB] FAIL directed_rdata_%0d: got %h want %h", i, r, t_exp[i]);
        end
      end
    end
  endtask

  task automatic test_faults();
    int low; logic d, e, ee; logic [31:0] r; bit early;
    logic        t_we   [5] = '{0, 1, 0, 1, 0};
    logic [31:0] t_addr [5] = '{32'h13, 32'h22, 32'h30, 32'h400, 32'h20};
    logic [1:0]  t_size [5] = '{1, 2, 3, 0, 2};
    logic        t_err  [5] = '{1, 1, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      issue(t_we[i], t_addr[i], t_size[i], 1'b0, 32'hA5A5_5A5A, 1'b0, low, d, e, r, early);
      model_exec(t_we[i], t_addr[i], t_size[i], 1'b0, 32'hA5A5_5A5A, ee);
      total++;
      if (low !== LATENCY || d !== 1'b1 || e !== t_err[i] || e !== ee || r !== ref_rdata) begin
        bad++;
        $display("[TB] FAIL fault_%0d: got low=%0d done=%b err=%b rdata=%h want %0d 1 %b %h",
                 i, low, d, e, r, LATENCY, t_err[i], ref_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    int low; logic d, e, ee; logic [31:0] r; bit early;
    logic [31:0] a [4];
    logic [31:0] w;
    for (int i = 0; i < 4; i++) a[i] = 32'(($urandom_range(0, DEPTH-1)) * 4);
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      issue(i < 4, a[i%4], 2'd2, 1'b0, w, 1'b1, low, d, e, r, early);
      model_exec(i < 4, a[i%4], 2'd2, 1'b0, w, ee);
      total++;
      if (low !== LATENCY || d !== 1'b1 || e !== 1'b0 || early || r !== ref_rdata) begin
        bad++;
        $display("[TB] FAIL b2b_%0d: got low=%0d done=%b err=%b rdata=%h want %0d 1 0 %h",
                 i, low, d, e, r, LATENCY, ref_rdata);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int low; logic d, e, ee; logic [31:0] r; bit early;
    logic we, uns; logic [31:0] addr, w; logic [1:0] size;
    for (int i = 0; i < 300; i++) begin
      we   = 1'($urandom);
      uns  = 1'($urandom);
      size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, DEPTH*4 + 15));
      w    = $urandom;
      issue(we, addr, size, uns, w, 1'($urandom), low, d, e, r, early);
      model_exec(we, addr, size, uns, w, ee);
      total++;
      if (low !== LATENCY || d !== 1'b1 || e !== ee || early || r !== ref_rdata) begin
        bad++;
        $display("[TB] FAIL random_%0d we=%b a=%h sz=%0d: got low=%0d done=%b err=%b rdata=%h want %0d 1 %b %h",
                 i, we, addr, size, low, d, e, r, LATENCY, ee, ref_rdata);
      end
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_done !== 1'b0 || dmem_valid !== 1'b1) begin
          bad++;
          $display("[TB] FAIL random_idle_%0d: got done=%b valid=%b want 0 1", i, rsp_done, dmem_valid);
        end
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int low; logic d, e, ee; logic [31:0] r; bit early;
    bit seen_done = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40;
    req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ref_rdata = 32'h0;
    @(negedge clk);
    total++;
    if (dmem_valid !== 1'b1 || rsp_done !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL abort_state: got valid=%b done=%b rdata=%h want 1 0 0",
               dmem_valid, rsp_done, rdata);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_done) seen_done = 1'b1;
    end
    total++;
    if (seen_done) begin
      bad++;
      $display("[TB] FAIL abort_no_done: got rsp_done=1 want 0");
    end
    issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0, low, d, e, r, early);
    model_exec(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, ee);
    total++;
    if (r !== ref_rdata || e !== 1'b0 || d !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_readback: got rdata=%h err=%b done=%b want %h 0 1",
               r, e, d, ref_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_faults();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
